// File: rtl/commit_pkg.sv
// Shared core definitions for the commit stage: rename geometry, reorder-info
// field offsets and the commit FSM state encoding.
package commit_pkg;

    localparam int RNBIT           = 2;
    localparam int RNDEPTH         = 1 << RNBIT;
    localparam int REORDER_INFO_DW = 64 + 5 + RNBIT + 3;
    localparam int WB_W            = 32 * RNDEPTH;
    localparam int IDX_W           = $clog2(WB_W);

    // reOrder_info = {pc, rd0_arch, rd0_reName, isBranch, isSu, isCsr}
    localparam int INFO_CSR      = 0;
    localparam int INFO_SU       = 1;
    localparam int INFO_BR       = 2;
    localparam int INFO_REN_LSB  = 3;
    localparam int INFO_ARCH_LSB = 3 + RNBIT;
    localparam int INFO_PC_LSB   = 8 + RNBIT;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_SU = 2'd1,
        ST_FLUSH   = 2'd2
    } commit_state_e;

    // RNDEPTH is a power of two, so arch*RNDEPTH+slot is a plain concatenation.
    function automatic logic [IDX_W-1:0] flag_idx(input logic [4:0] arch,
                                                  input logic [RNBIT-1:0] slot);
        return {arch, slot};
    endfunction

endpackage

// File: rtl/commit_archi_table.sv
// Committed architectural rename table: 32 x RNBIT registers, one write port,
// flat read bus with entry r at bits [r*RNBIT +: RNBIT].
module archi_table
    import commit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [RNBIT-1:0]      wr_data,
    output logic [RNBIT*32-1:0]   table_q
);

    logic [RNBIT-1:0] regs [32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) regs[r] <= '0;
        end else if (wr_en && wr_addr != 5'd0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < 32; g++) begin : g_rd
        assign table_q[g*RNBIT +: RNBIT] = regs[g];
    end

endmodule

// File: rtl/commit.sv
// In-order commit stage: retires the reorder-FIFO head, frees the previous
// physical mapping, handles branch flush and store handshake.
// Optional retired-instruction counter enabled by defining COMMIT_INSTRET_EN.
module commit
    import commit_pkg::*;
(
    input  logic                        CLK,
    input  logic                        RSTn,
    input  logic                        reOrder_fifo_empty,
    input  logic [REORDER_INFO_DW-1:0]  reOrder_info,
    output logic                        reOrder_fifo_pop,
    input  logic [WB_W-1:0]             wbLog_qout,
    output logic [WB_W-1:0]             wbLog_commit_rst,
    output logic [WB_W-1:0]             rnBufU_commit_rst,
    output logic [RNBIT*32-1:0]         archi_X_qout,
    input  logic                        bru_res_valid,
    input  logic                        bru_mispredict,
    output logic                        bru_res_pop,
    output logic                        su_commit,
    input  logic                        su_commit_ack,
    output logic                        flush,
    output logic [63:0]                 commit_instret
);

    commit_state_e    state;
    logic [4:0]       rd0_arch;
    logic [RNBIT-1:0] rd0_rename;
    logic [RNBIT-1:0] old_rename;
    logic             is_branch;
    logic             is_su;
    logic             plain_ready;
    logic             pop;
    logic             arch_wr;
    logic [WB_W-1:0]  free_onehot;
    logic [64:0]      unused_info;

    assign rd0_arch    = reOrder_info[INFO_ARCH_LSB +: 5];
    assign rd0_rename  = reOrder_info[INFO_REN_LSB +: RNBIT];
    assign is_branch   = reOrder_info[INFO_BR];
    assign is_su       = reOrder_info[INFO_SU];
    assign unused_info = {reOrder_info[INFO_PC_LSB +: 64], reOrder_info[INFO_CSR]};
    assign plain_ready = (rd0_arch == 5'd0) || wbLog_qout[flag_idx(rd0_arch, rd0_rename)];
    assign old_rename  = archi_X_qout[rd0_arch*RNBIT +: RNBIT];

    // Pops are combinational so a ready head retires in the cycle it becomes ready.
    always_comb begin
        pop         = 1'b0;
        bru_res_pop = 1'b0;
        su_commit   = 1'b0;
        case (state)
            ST_RUN: begin
                if (!reOrder_fifo_empty) begin
                    if (is_branch) begin
                        pop         = bru_res_valid;
                        bru_res_pop = bru_res_valid;
                    end else if (is_su) begin
                        su_commit = 1'b1;
                        pop       = su_commit_ack;
                    end else begin
                        pop = plain_ready;
                    end
                end
            end
            ST_WAIT_SU: begin
                su_commit = 1'b1;
                pop       = su_commit_ack;
            end
            default: ;
        endcase
        if (!RSTn) begin
            pop         = 1'b0;
            bru_res_pop = 1'b0;
            su_commit   = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!reOrder_fifo_empty) begin
                        if (is_branch) begin
                            if (bru_res_valid && bru_mispredict) state <= ST_FLUSH;
                        end else if (is_su && !su_commit_ack) begin
                            state <= ST_WAIT_SU;
                        end
                    end
                end
                ST_WAIT_SU: if (su_commit_ack) state <= ST_RUN;
                default:    state <= ST_RUN;
            endcase
        end
    end

    assign reOrder_fifo_pop = pop;
    assign flush            = RSTn && (state == ST_FLUSH);

    // Retiring a new mapping for rd frees the one it replaces.
    assign arch_wr           = pop && (rd0_arch != 5'd0);
    assign free_onehot       = WB_W'(1) << flag_idx(rd0_arch, old_rename);
    assign wbLog_commit_rst  = arch_wr ? free_onehot : '0;
    assign rnBufU_commit_rst = arch_wr ? free_onehot : '0;

    archi_table u_archi_table (
        .clk     (CLK),
        .rst_n   (RSTn),
        .wr_en   (arch_wr),
        .wr_addr (rd0_arch),
        .wr_data (rd0_rename),
        .table_q (archi_X_qout)
    );

`ifdef COMMIT_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge CLK) begin
        if (!RSTn)    instret_q <= '0;
        else if (pop) instret_q <= instret_q + 64'd1;
    end

    assign commit_instret = instret_q;
`else
    assign commit_instret = '0;
`endif

endmodule

// File: tb/tb_commit.sv
// Directed bench for the commit stage; expected values are hand-computed.
// Expectations for the retired-instruction counter follow COMMIT_INSTRET_EN.
module tb_commit;
    import commit_pkg::*;

    logic                       CLK = 1'b0;
    logic                       RSTn;
    logic                       reOrder_fifo_empty;
    logic [REORDER_INFO_DW-1:0] reOrder_info;
    logic                       reOrder_fifo_pop;
    logic [WB_W-1:0]            wbLog_qout;
    logic [WB_W-1:0]            wbLog_commit_rst;
    logic [WB_W-1:0]            rnBufU_commit_rst;
    logic [RNBIT*32-1:0]        archi_X_qout;
    logic                       bru_res_valid;
    logic                       bru_mispredict;
    logic                       bru_res_pop;
    logic                       su_commit;
    logic                       su_commit_ack;
    logic                       flush;
    logic [63:0]                commit_instret;

    int total = 0;
    int bad   = 0;

    commit dut (
        .CLK               (CLK),
        .RSTn              (RSTn),
        .reOrder_fifo_empty(reOrder_fifo_empty),
        .reOrder_info      (reOrder_info),
        .reOrder_fifo_pop  (reOrder_fifo_pop),
        .wbLog_qout        (wbLog_qout),
        .wbLog_commit_rst  (wbLog_commit_rst),
        .rnBufU_commit_rst (rnBufU_commit_rst),
        .archi_X_qout      (archi_X_qout),
        .bru_res_valid     (bru_res_valid),
        .bru_mispredict    (bru_mispredict),
        .bru_res_pop       (bru_res_pop),
        .su_commit         (su_commit),
        .su_commit_ack     (su_commit_ack),
        .flush             (flush),
        .commit_instret    (commit_instret)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [REORDER_INFO_DW-1:0] mk(input logic [4:0] arch,
                                                     input logic [RNBIT-1:0] ren,
                                                     input logic br, input logic su,
                                                     input logic csr);
        return {64'h0000_0000_8000_1000, arch, ren, br, su, csr};
    endfunction

    logic [63:0] exp_cnt;

    initial begin
        RSTn = 1'b0; reOrder_fifo_empty = 1'b1; reOrder_info = '0; wbLog_qout = '0;
        bru_res_valid = 1'b0; bru_mispredict = 1'b0; su_commit_ack = 1'b0;
        tick(); tick();
        RSTn = 1'b1; settle();
        chk("rst_pop", reOrder_fifo_pop, 0);
        chk("rst_flush", flush, 0);
        chk("rst_su", su_commit, 0);
        chk("rst_archi", archi_X_qout, 0);
        chk("rst_instret", commit_instret, 0);
        chk("rst_wbrst", wbLog_commit_rst, 0);
        chk("empty_bpop", bru_res_pop, 0);

        // plain retire: rd5 -> slot 2, frees slot 0 of x5
        tick();
        reOrder_fifo_empty = 1'b0; reOrder_info = mk(5, 2, 0, 0, 0);
        wbLog_qout = 128'h1 << 22; settle();
        chk("p5_pop", reOrder_fifo_pop, 1);
        chk("p5_wbrst", wbLog_commit_rst, 128'h1 << 20);
        chk("p5_rnrst", rnBufU_commit_rst, 128'h1 << 20);
        tick();
        reOrder_fifo_empty = 1'b1; wbLog_qout = '0; settle();
        chk("p5_archi", archi_X_qout[11:10], 2);
        chk("p5_nopop", reOrder_fifo_pop, 0);
        chk("p5_rst0", wbLog_commit_rst, 0);

        // head waits on written-back flag for 10 cycles
        reOrder_fifo_empty = 1'b0; reOrder_info = mk(7, 3, 0, 0, 0); settle();
        for (int i = 0; i < 10; i++) begin
            chk("wait_pop", reOrder_fifo_pop, 0);
            tick();
        end
        wbLog_qout = 128'h1 << 31; settle();
        chk("w7_pop", reOrder_fifo_pop, 1);
        chk("w7_rst", rnBufU_commit_rst, 128'h1 << 28);
        tick();
        // remap x5: the freed slot is now 2
        reOrder_info = mk(5, 1, 0, 0, 0); wbLog_qout = 128'h1 << 21; settle();
        chk("w7_archi", archi_X_qout[15:14], 3);
        chk("r5_pop", reOrder_fifo_pop, 1);
        chk("r5_wbrst", wbLog_commit_rst, 128'h1 << 22);
        tick();
        // x0 destination retires without a flag and frees nothing
        reOrder_info = mk(0, 3, 0, 0, 0); wbLog_qout = '0; settle();
        chk("r5_archi", archi_X_qout[11:10], 1);
        chk("x0_pop", reOrder_fifo_pop, 1);
        chk("x0_rst", wbLog_commit_rst, 0);
        tick();
        // CSR head: same readiness rule
        reOrder_info = mk(3, 1, 0, 0, 1); settle();
        chk("csr_wait", reOrder_fifo_pop, 0);
        tick();
        wbLog_qout = 128'h1 << 13; settle();
        chk("csr_pop", reOrder_fifo_pop, 1);
        chk("csr_rst", wbLog_commit_rst, 128'h1 << 12);
        tick();
        wbLog_qout = '0;

        // mispredicted branch after 3 cycles
        reOrder_info = mk(0, 0, 1, 0, 0); settle();
        chk("csr_archi", archi_X_qout[7:6], 1);
        for (int i = 0; i < 3; i++) begin
            chk("br_wait_pop", reOrder_fifo_pop, 0);
            chk("br_wait_bpop", bru_res_pop, 0);
            tick();
        end
        bru_res_valid = 1'b1; bru_mispredict = 1'b1; settle();
        chk("br_pop", reOrder_fifo_pop, 1);
        chk("br_bpop", bru_res_pop, 1);
        chk("br_noflush", flush, 0);
        tick();
        bru_res_valid = 1'b0; bru_mispredict = 1'b0;
        reOrder_info = mk(0, 0, 0, 0, 0); settle();
        chk("fl_flush", flush, 1);
        chk("fl_nopop", reOrder_fifo_pop, 0);
        tick();
        chk("fl_done", flush, 0);
        chk("fl_after_pop", reOrder_fifo_pop, 1);
        tick();
        // correctly predicted branch stays in RUN
        reOrder_info = mk(0, 0, 1, 0, 0); bru_res_valid = 1'b1; settle();
        chk("bok_pop", reOrder_fifo_pop, 1);
        tick();
        reOrder_fifo_empty = 1'b1; bru_res_valid = 1'b0; settle();
        chk("bok_noflush", flush, 0);
        tick();

        // store with ack 4 cycles after su_commit rises
        reOrder_fifo_empty = 1'b0; reOrder_info = mk(0, 0, 0, 1, 0); settle();
        for (int i = 0; i < 4; i++) begin
            chk("st_su", su_commit, 1);
            chk("st_nopop", reOrder_fifo_pop, 0);
            tick();
        end
        su_commit_ack = 1'b1; settle();
        chk("st_ack_su", su_commit, 1);
        chk("st_ack_pop", reOrder_fifo_pop, 1);
        tick();
        su_commit_ack = 1'b0; reOrder_fifo_empty = 1'b1; settle();
        chk("st_done_su", su_commit, 0);
        chk("st_done_pop", reOrder_fifo_pop, 0);
        tick();

        // ack in the same cycle su_commit rises
        reOrder_fifo_empty = 1'b0; su_commit_ack = 1'b1; settle();
        chk("sq_pop", reOrder_fifo_pop, 1);
        tick();
        reOrder_fifo_empty = 1'b1; su_commit_ack = 1'b0; settle();
        chk("sq_run", su_commit, 0);
        tick();

        // reset during WAIT_SU aborts the store
        reOrder_fifo_empty = 1'b0; settle();
        tick();
        chk("rw_su", su_commit, 1);
        RSTn = 1'b0; su_commit_ack = 1'b1; settle();
        chk("rw_nopop", reOrder_fifo_pop, 0);
        tick();
        RSTn = 1'b1; su_commit_ack = 1'b0; reOrder_fifo_empty = 1'b1; settle();
        chk("rw_su0", su_commit, 0);
        chk("rw_archi", archi_X_qout, 0);
        chk("rw_instret", commit_instret, 0);
        chk("rw_pop", reOrder_fifo_pop, 0);
        chk("rw_flush", flush, 0);

        // 100 back-to-back retirable heads
        reOrder_fifo_empty = 1'b0; reOrder_info = mk(0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) tick();
        reOrder_fifo_empty = 1'b1; settle();
`ifdef COMMIT_INSTRET_EN
        exp_cnt = 64'd100;
`else
        exp_cnt = 64'd0;
`endif
        chk("instret", commit_instret, exp_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
